// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - load/store type encodings coming from decode
//   - LSU state encoding
//   - alignment helper functions used by the top level
package mem_access_unit_pkg;

    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_HD  = 3'd1;   // signed halfword
    localparam logic [2:0] LOAD_LW  = 3'd2;
    localparam logic [2:0] LOAD_LBU = 3'd3;
    localparam logic [2:0] LOAD_LHU = 3'd4;
    localparam logic [2:0] LOAD_DEF = 3'd7;   // behaves as LW

    localparam logic [1:0] STORE_SB  = 2'd0;
    localparam logic [1:0] STORE_SH  = 2'd1;
    localparam logic [1:0] STORE_SW  = 2'd2;
    localparam logic [1:0] STORE_DEF = 2'd3;  // no memory access

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_REQ      = 2'd1,
        LSU_WAIT_RSP = 2'd2,
        LSU_DONE     = 2'd3
    } lsu_state_e;

    // Bytes are always aligned; halves need an even address; words (and any
    // unrecognised type, which falls back to word) need addr[1:0] == 0.
    function automatic logic load_is_misaligned(input logic [2:0] load_type,
                                                input logic [1:0] offset);
        case (load_type)
            LOAD_LB, LOAD_LBU:  return 1'b0;
            LOAD_HD, LOAD_LHU:  return offset[0];
            default:            return offset != 2'b00;
        endcase
    endfunction

    function automatic logic store_is_misaligned(input logic [1:0] store_type,
                                                 input logic [1:0] offset);
        case (store_type)
            STORE_SB: return 1'b0;
            STORE_SH: return offset[0];
            default:  return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data formatter: picks the addressed byte/halfword lane out of the
// returned memory word and sign- or zero-extends it to 32 bits.
//   rdata_i     : 32-bit word read from memory
//   offset_i    : byte offset addr[1:0] of the access
//   load_type_i : load type (LB/HD/LW/LBU/LHU/DEF)
//   result_o    : extended result for writeback
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  load_type_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every signal driven here gets a value before the case statement,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_lane = rdata_i[{offset_i, 3'b000} +: 8];
        half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        result_o  = rdata_i;
        case (load_type_i)
            LOAD_LB:  result_o = {{24{byte_lane[7]}}, byte_lane};
            LOAD_LBU: result_o = {24'h0, byte_lane};
            LOAD_HD:  result_o = {{16{half_lane[15]}}, half_lane};
            LOAD_LHU: result_o = {16'h0, half_lane};
            LOAD_LW:  result_o = rdata_i;
            default:  result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit. Takes the decoded memory controls of the
// instruction in the memory stage and performs the access on a valid/ready
// request + valid response data-memory port, stalling the pipeline while the
// access is in flight.
//   clk, rst_n                         : clock, synchronous active-low reset
//   op_valid, mem_write, wb_load       : live slot, store, load
//   mem_load_type, mem_store_type      : access size / extension
//   addr, store_data                   : byte address and rs2 value
//   req_valid/ready, req_we, req_addr,
//   req_wdata, req_wstrb               : memory request channel
//   rsp_valid, rsp_rdata               : memory read response
//   load_data, load_valid              : extended load result, one-cycle valid
//   misaligned                         : one-cycle misaligned-access pulse
//   lsu_stall                          : hold the pipeline
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    input  logic                  mem_write,
    input  logic                  wb_load,
    input  logic [2:0]            mem_load_type,
    input  logic [1:0]            mem_store_type,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_we,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [31:0]           req_wdata,
    output logic [3:0]            req_wstrb,
    input  logic                  rsp_valid,
    input  logic [31:0]           rsp_rdata,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  misaligned,
    output logic                  lsu_stall
);

    lsu_state_e            state_q, state_d;
    logic                  req_we_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [31:0]           req_wdata_q;
    logic [3:0]            req_wstrb_q;
    logic [2:0]            ld_type_q;
    logic [1:0]            ld_off_q;
    logic [31:0]           load_data_q;
    logic                  misaligned_q;

    logic        is_store;
    logic        is_load;
    logic        access_needed;
    logic        access_misaligned;
    logic        start;
    logic [31:0] wdata_new;
    logic [3:0]  wstrb_new;
    logic [31:0] aligned_data;

    // A store with STORE_DEF is not a memory operation. If decode ever flags
    // both, a real store takes precedence over the load.
    assign is_store      = op_valid && mem_write && (mem_store_type != STORE_DEF);
    assign is_load       = op_valid && wb_load && !is_store;
    assign access_needed = is_store || is_load;

    assign access_misaligned = is_store ? store_is_misaligned(mem_store_type, addr[1:0])
                                        : load_is_misaligned(mem_load_type, addr[1:0]);

    // Only IDLE accepts; an instruction still presented in DONE has already
    // been served and is not restarted.
    assign start = (state_q == LSU_IDLE) && access_needed && !access_misaligned;

    // Lane-position the store data and build the byte strobes.
    always_comb begin
        wdata_new = '0;
        wstrb_new = '0;
        if (is_store) begin
            case (mem_store_type)
                STORE_SB: begin
                    wdata_new = {4{store_data[7:0]}};
                    wstrb_new = 4'b0001 << addr[1:0];
                end
                STORE_SH: begin
                    wdata_new = {2{store_data[15:0]}};
                    wstrb_new = 4'b0011 << {addr[1], 1'b0};
                end
                STORE_SW: begin
                    wdata_new = store_data;
                    wstrb_new = 4'hF;
                end
                default: begin
                    wdata_new = '0;
                    wstrb_new = '0;
                end
            endcase
        end
    end

    load_align u_load_align (
        .rdata_i     (rsp_rdata),
        .offset_i    (ld_off_q),
        .load_type_i (ld_type_q),
        .result_o    (aligned_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:     if (start) state_d = LSU_REQ;
            LSU_REQ:      if (req_ready) state_d = req_we_q ? LSU_DONE : LSU_WAIT_RSP;
            LSU_WAIT_RSP: if (rsp_valid) state_d = LSU_DONE;
            LSU_DONE:     state_d = LSU_IDLE;
            default:      state_d = LSU_IDLE;
        endcase
    end

    // Request fields are captured once at acceptance so they hold steady
    // through any back-pressure, even if upstream values wobble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
            ld_type_q    <= LOAD_LB;
            ld_off_q     <= 2'b00;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= (state_q == LSU_IDLE) && access_needed && access_misaligned;
            if (start) begin
                req_we_q    <= is_store;
                req_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                req_wdata_q <= wdata_new;
                req_wstrb_q <= wstrb_new;
                ld_type_q   <= mem_load_type;
                ld_off_q    <= addr[1:0];
            end
            if ((state_q == LSU_WAIT_RSP) && rsp_valid) begin
                load_data_q <= aligned_data;
            end
        end
    end

    // Control outputs are gated by rst_n so they read 0 for the whole reset
    // window, not only after the first reset edge.
    assign req_valid  = rst_n && (state_q == LSU_REQ);
    assign lsu_stall  = rst_n && (start || (state_q == LSU_REQ) || (state_q == LSU_WAIT_RSP));
    assign load_valid = rst_n && (state_q == LSU_DONE) && !req_we_q;
    assign misaligned = rst_n && misaligned_q;

    assign req_we    = req_we_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign req_wstrb = req_wstrb_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. Expected requests and load
// results are queued when an instruction is driven and popped when the DUT
// presents the matching request / load_valid.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        mem_write;
    logic        wb_load;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_store_type;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        lsu_stall;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_load_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op_valid       (op_valid),
        .mem_write      (mem_write),
        .wb_load        (wb_load),
        .mem_load_type  (mem_load_type),
        .mem_store_type (mem_store_type),
        .addr           (addr),
        .store_data     (store_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .misaligned     (misaligned),
        .lsu_stall      (lsu_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] model_wstrb(input logic [1:0] st, input logic [31:0] a);
        case (st)
            STORE_SB: case (a[1:0])
                          2'd0: return 4'b0001;
                          2'd1: return 4'b0010;
                          2'd2: return 4'b0100;
                          default: return 4'b1000;
                      endcase
            STORE_SH: return a[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] st, input logic [31:0] sd);
        case (st)
            STORE_SB: return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            STORE_SH: return {sd[15:0], sd[15:0]};
            default:  return sd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] s;
        s = rdata >> (8 * a[1:0]);
        case (lt)
            LOAD_LB:  return {{24{s[7]}}, s[7:0]};
            LOAD_LBU: return {24'h0, s[7:0]};
            LOAD_HD:  return {{16{s[15]}}, s[15:0]};
            LOAD_LHU: return {16'h0, s[15:0]};
            default:  return rdata;
        endcase
    endfunction

    task automatic idle_inputs();
        op_valid       = 1'b0;
        mem_write      = 1'b0;
        wb_load        = 1'b0;
        mem_load_type  = LOAD_LW;
        mem_store_type = STORE_DEF;
        addr           = '0;
        store_data     = '0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rdata      = '0;
    endtask

    // All tasks start and end at posedge + 1.
    task automatic run_access(input string name, input logic is_st, input logic [2:0] lt,
                              input logic [1:0] st, input logic [31:0] a, input logic [31:0] sd,
                              input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
        req_t        er;
        logic [31:0] exp_ld;
        int          rdy_cnt = 0;
        int          rsp_cnt = 0;
        int          edges   = 0;
        int          exp_edges;
        bit          hs_pending = 0;
        bit          accepted   = 0;
        bit          done       = 0;

        er.we    = is_st;
        er.addr  = {a[31:2], 2'b00};
        er.wdata = is_st ? model_wdata(st, sd) : 32'h0;
        er.wstrb = is_st ? model_wstrb(st, a) : 4'h0;
        exp_req_q.push_back(er);
        if (!is_st) exp_load_q.push_back(model_load(lt, a, rdata));
        exp_edges = is_st ? (2 + rdy_dly) : (3 + rdy_dly + rsp_dly);

        op_valid = 1'b1; mem_write = is_st; wb_load = !is_st;
        mem_load_type = lt; mem_store_type = st; addr = a; store_data = sd;
        #1;
        n_assert++;
        if (lsu_stall !== 1'b1) begin
            n_fail++; $display("FAIL %s stall_on_accept: got %b want 1", name, lsu_stall);
        end

        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk); #1;
            rsp_valid = 1'b0;
            if (hs_pending) begin
                hs_pending = 0;
                accepted   = 1;
                req_ready  = 1'b0;
                void'(exp_req_q.pop_front());
            end
            if (req_valid === 1'b1) begin
                n_assert++;
                if (exp_req_q.size() == 0) begin
                    n_fail++; $display("FAIL %s extra_request: req_valid with nothing expected", name);
                end else if ({req_we, req_addr, req_wdata, req_wstrb} !==
                             {exp_req_q[0].we, exp_req_q[0].addr, exp_req_q[0].wdata, exp_req_q[0].wstrb}) begin
                    n_fail++;
                    $display("FAIL %s request: got we=%b addr=%h wdata=%h wstrb=%b want we=%b addr=%h wdata=%h wstrb=%b",
                             name, req_we, req_addr, req_wdata, req_wstrb,
                             exp_req_q[0].we, exp_req_q[0].addr, exp_req_q[0].wdata, exp_req_q[0].wstrb);
                end
                n_assert++;
                if (lsu_stall !== 1'b1) begin
                    n_fail++; $display("FAIL %s stall_in_req: got %b want 1", name, lsu_stall);
                end
                if (rdy_cnt >= rdy_dly) begin
                    req_ready  = 1'b1;
                    hs_pending = 1;
                end else begin
                    rdy_cnt++;
                end
            end else if (lsu_stall === 1'b1) begin
                if (rsp_cnt >= rsp_dly) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = rdata;
                end else begin
                    rsp_cnt++;
                end
            end else begin
                done  = 1;
                edges = c;
            end
        end

        n_assert++;
        if (!done) begin
            n_fail++; $display("FAIL %s timeout: access never completed within 40 cycles", name);
            idle_inputs();
            return;
        end
        if (!accepted || edges != exp_edges) begin
            n_fail++; $display("FAIL %s latency: got %0d cycles (accepted=%0d) want %0d", name, edges, accepted, exp_edges);
        end
        n_assert++;
        if (load_valid !== !is_st) begin
            n_fail++; $display("FAIL %s load_valid_in_done: got %b want %b", name, load_valid, !is_st);
        end
        if (!is_st) begin
            exp_ld = exp_load_q.pop_front();
            n_assert++;
            if (load_data !== exp_ld) begin
                n_fail++; $display("FAIL %s load_data: got %h want %h", name, load_data, exp_ld);
            end
        end

        idle_inputs();
        @(posedge clk); #1;
        n_assert++;
        if ({load_valid, req_valid, lsu_stall, misaligned} !== 4'b0000) begin
            n_fail++; $display("FAIL %s after_done: got lv/rv/stall/mis=%b want 0000",
                               name, {load_valid, req_valid, lsu_stall, misaligned});
        end
    endtask

    task automatic run_misaligned(input string name, input logic is_st, input logic [2:0] lt,
                                  input logic [1:0] st, input logic [31:0] a);
        op_valid = 1'b1; mem_write = is_st; wb_load = !is_st;
        mem_load_type = lt; mem_store_type = st; addr = a; store_data = 32'hCAFEF00D;
        #1;
        n_assert++;
        if (lsu_stall !== 1'b0) begin
            n_fail++; $display("FAIL %s stall: got %b want 0", name, lsu_stall);
        end
        @(posedge clk); #1;
        n_assert++;
        if ({misaligned, req_valid, load_valid, lsu_stall} !== 4'b1000) begin
            n_fail++; $display("FAIL %s pulse: got mis/rv/lv/stall=%b want 1000",
                               name, {misaligned, req_valid, load_valid, lsu_stall});
        end
        idle_inputs();
        @(posedge clk); #1;
        n_assert++;
        if ({misaligned, req_valid, load_valid, lsu_stall} !== 4'b0000) begin
            n_fail++; $display("FAIL %s pulse_end: got mis/rv/lv/stall=%b want 0000",
                               name, {misaligned, req_valid, load_valid, lsu_stall});
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // A live aligned load during reset must not raise the stall.
        op_valid = 1'b1; wb_load = 1'b1; mem_load_type = LOAD_LW; addr = 32'h40;
        #1;
        n_assert++;
        if ({req_valid, req_we, req_addr, req_wdata, req_wstrb, load_data, load_valid, misaligned, lsu_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv=%b we=%b addr=%h wd=%h ws=%b ld=%h lv=%b mis=%b stall=%b want all 0",
                     req_valid, req_we, req_addr, req_wdata, req_wstrb, load_data, load_valid, misaligned, lsu_stall);
        end
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stores();
        run_access("sw_0x100",  1'b1, LOAD_LW, STORE_SW, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        run_access("sb_0x103",  1'b1, LOAD_LW, STORE_SB, 32'h103, 32'h000000A5, 0, 0, 32'h0);
        run_access("sh_0x102",  1'b1, LOAD_LW, STORE_SH, 32'h102, 32'h1234ABCD, 0, 0, 32'h0);
        run_access("sb_0x201",  1'b1, LOAD_LW, STORE_SB, 32'h201, 32'hFFFFFF3C, 1, 0, 32'h0);
    endtask

    task automatic test_loads();
        run_access("lb_0x102",   1'b0, LOAD_LB,  STORE_DEF, 32'h102, 32'h0, 0, 0, 32'h12803456);
        run_access("lbu_0x102",  1'b0, LOAD_LBU, STORE_DEF, 32'h102, 32'h0, 0, 0, 32'h12803456);
        run_access("lb_0x103",   1'b0, LOAD_LB,  STORE_DEF, 32'h103, 32'h0, 0, 1, 32'h7F00FF00);
        run_access("lh_0x102",   1'b0, LOAD_HD,  STORE_DEF, 32'h102, 32'h0, 0, 0, 32'h80011234);
        run_access("lhu_0x102",  1'b0, LOAD_LHU, STORE_DEF, 32'h102, 32'h0, 0, 0, 32'h80011234);
        run_access("lh_0x100",   1'b0, LOAD_HD,  STORE_DEF, 32'h100, 32'h0, 0, 0, 32'h0000F00F);
        run_access("ldef_0x104", 1'b0, LOAD_DEF, STORE_DEF, 32'h104, 32'h0, 0, 0, 32'h89ABCDEF);
    endtask

    task automatic test_back_pressure();
        run_access("lw_backpressure", 1'b0, LOAD_LW, STORE_DEF, 32'h300, 32'h0, 4, 2, 32'hA5A55A5A);
        run_access("sw_backpressure", 1'b1, LOAD_LW, STORE_SW, 32'h304, 32'h01020304, 3, 0, 32'h0);
    endtask

    task automatic test_misaligned();
        run_misaligned("mis_lh_0x101",  1'b0, LOAD_HD,  STORE_DEF, 32'h101);
        run_misaligned("mis_lhu_0x103", 1'b0, LOAD_LHU, STORE_DEF, 32'h103);
        run_misaligned("mis_lw_0x102",  1'b0, LOAD_LW,  STORE_DEF, 32'h102);
        run_misaligned("mis_sw_0x102",  1'b1, LOAD_LW,  STORE_SW,  32'h102);
        run_misaligned("mis_sh_0x101",  1'b1, LOAD_LW,  STORE_SH,  32'h101);
    endtask

    task automatic test_store_def();
        op_valid = 1'b1; mem_write = 1'b1; mem_store_type = STORE_DEF; addr = 32'h100;
        #1;
        n_assert++;
        if (lsu_stall !== 1'b0) begin
            n_fail++; $display("FAIL store_def_stall: got %b want 0", lsu_stall);
        end
        @(posedge clk); #1;
        n_assert++;
        if ({req_valid, misaligned, load_valid} !== 3'b000) begin
            n_fail++; $display("FAIL store_def_no_access: got rv/mis/lv=%b want 000",
                               {req_valid, misaligned, load_valid});
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        op_valid = 1'b1; wb_load = 1'b1; mem_load_type = LOAD_LW; addr = 32'h200;
        req_ready = 1'b1;
        @(posedge clk); #1;
        n_assert++;
        if (req_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_req: got req_valid=%b want 1", req_valid);
        end
        @(posedge clk); #1;
        req_ready = 1'b0;
        n_assert++;
        if ({req_valid, lsu_stall} !== 2'b01) begin
            n_fail++; $display("FAIL rst_mid_wait: got rv/stall=%b want 01", {req_valid, lsu_stall});
        end
        rst_n = 1'b0;
        #1;
        n_assert++;
        if (lsu_stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_stall_forced: got %b want 0", lsu_stall);
        end
        idle_inputs();
        @(posedge clk); #1;
        n_assert++;
        if ({req_valid, load_valid, misaligned, lsu_stall, req_we, req_wstrb} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got rv/lv/mis/stall/we/wstrb=%b want 0",
                               {req_valid, load_valid, misaligned, lsu_stall, req_we, req_wstrb});
        end
        rst_n = 1'b1;
        rsp_valid = 1'b1; rsp_rdata = 32'h55555555;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if ({load_valid, lsu_stall, req_valid} !== 3'b000) begin
                n_fail++; $display("FAIL rst_late_rsp_%0d: got lv/stall/rv=%b want 000", i,
                                   {load_valid, lsu_stall, req_valid});
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_stores();
        test_loads();
        test_back_pressure();
        test_misaligned();
        test_store_def();
        test_reset_mid_access();
        // Back-to-back accesses after a reset recovery.
        run_access("b2b_sw", 1'b1, LOAD_LW, STORE_SW, 32'h400, 32'h11223344, 0, 0, 32'h0);
        run_access("b2b_lw", 1'b0, LOAD_LW, STORE_DEF, 32'h400, 32'h0, 0, 0, 32'h11223344);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
